// File: rtl/wb_spram_pkg.sv
// Shared types and constants for the Wishbone single-port RAM controller.
package wb_spram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int WB_SEL_W = 4;
  localparam int WB_DW    = 32;

endpackage

// File: rtl/spram_clear_fsm.sv
// Post-reset zero-fill sequencer: walks every RAM word once, then hands the
// RAM over to the bus for good (only reset brings it back to CLEAR).
module spram_clear_fsm
  import wb_spram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 14,
  parameter bit CLEAR_ON_RESET = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  clear_active,
  output logic [ADDR_WIDTH-1:0] clear_addr
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // State and word counter registers; reset restarts the fill from word 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // One word per cycle; the last word (all ones) is written in the final CLEAR cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q == '1) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign clear_active = (state_q == CLEAR);
  assign clear_addr   = cnt_q;

endmodule

// File: rtl/wb_spram_ctrl.sv
// Wishbone B4 pipelined slave in front of a single-port 32-bit RAM with
// 1-cycle read latency. Decodes its address window, answers out-of-window
// accesses with err, and optionally zero-fills the RAM after reset.
module wb_spram_ctrl
  import wb_spram_pkg::*;
#(
  parameter int          SIZE           = 'h10000,
  parameter int          ADDR_WIDTH     = $clog2(SIZE) - 2,
  parameter logic [31:0] BASE           = 32'h0,
  parameter bit          OUT_REG        = 1'b0,
  parameter bit          CLEAR_ON_RESET = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [WB_SEL_W-1:0]   wb_sel,
  input  logic [31:0]           wb_adr,
  input  logic [WB_DW-1:0]      wb_dat_i,
  output logic                  wb_stall,
  output logic                  wb_ack,
  output logic                  wb_err,
  output logic [WB_DW-1:0]      wb_dat_o,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_ce,
  output logic [WB_SEL_W-1:0]   ram_we,
  output logic [WB_DW-1:0]      ram_d,
  input  logic [WB_DW-1:0]      ram_q
);

  localparam logic [31:0] SIZE_B = 32'(SIZE);

  logic                  clear_active;
  logic [ADDR_WIDTH-1:0] clear_addr;
  logic [31:0]           off;
  logic                  in_range;
  logic                  accept;
  logic                  p1_v;
  logic                  p1_err;
  logic                  resp_ack;
  logic                  resp_err;

  spram_clear_fsm #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .clk          (clk),
    .rst          (rst),
    .clear_active (clear_active),
    .clear_addr   (clear_addr)
  );

  // The window never wraps: anything below BASE or at/after BASE+SIZE is an error.
  assign off      = wb_adr - BASE;
  assign in_range = (wb_adr >= BASE) && (off < SIZE_B);
  assign accept   = wb_cyc & wb_stb & ~clear_active;
  assign wb_stall = clear_active;

  // RAM port mux: the fill sequencer owns the RAM while clearing, the bus afterwards.
  always_comb begin
    ram_ce   = 1'b0;
    ram_we   = '0;
    ram_d    = wb_dat_i;
    ram_addr = off[ADDR_WIDTH+1:2];
    if (clear_active) begin
      ram_ce   = 1'b1;
      ram_we   = '1;
      ram_d    = '0;
      ram_addr = clear_addr;
    end else if (accept && in_range) begin
      ram_ce = 1'b1;
      ram_we = wb_we ? wb_sel : '0;
    end
  end

  // First response stage lines up with the RAM read latency; dropping cyc flushes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_v   <= 1'b0;
      p1_err <= 1'b0;
    end else if (!wb_cyc) begin
      p1_v   <= 1'b0;
      p1_err <= 1'b0;
    end else begin
      p1_v   <= accept;
      p1_err <= accept & ~in_range;
    end
  end

  assign resp_ack = p1_v & ~p1_err & wb_cyc;
  assign resp_err = p1_v & p1_err & wb_cyc;

  generate
    if (OUT_REG) begin : g_out_reg
      logic             ack_q;
      logic             err_q;
      logic [WB_DW-1:0] dat_q;

      // Registered response: one extra cycle of latency, outputs come straight from flops.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          dat_q <= '0;
        end else begin
          ack_q <= resp_ack;
          err_q <= resp_err;
          dat_q <= ram_q;
        end
      end

      assign wb_ack   = ack_q;
      assign wb_err   = err_q;
      assign wb_dat_o = dat_q;
    end else begin : g_out_comb
      assign wb_ack   = resp_ack;
      assign wb_err   = resp_err;
      assign wb_dat_o = p1_v ? ram_q : '0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_spram_ctrl.sv
// Self-checking bench: two controller instances (combinational response with
// post-reset clear, and registered response without clear), each backed by a
// behavioural RAM, checked against a reference memory and response queue.
module tb_wb_spram_ctrl;

  localparam int          SIZE  = 'h80;
  localparam int          WORDS = SIZE / 4;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]       cyc, stb, we;
  logic [1:0][3:0]  sel;
  logic [1:0][31:0] adr, dat_i;
  logic [1:0]       stall, ack, err, ram_ce;
  logic [1:0][31:0] dat_o, ram_d;
  logic [1:0][4:0]  ram_addr;
  logic [1:0][3:0]  ram_we;

  logic [31:0] ref_mem [2][WORDS];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [31:0] mem [WORDS];
    logic [31:0] q;

    wb_spram_ctrl #(
      .SIZE           (SIZE),
      .BASE           (g == 0 ? BASE0 : BASE1),
      .OUT_REG        (g != 0),
      .CLEAR_ON_RESET (g == 0)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .wb_cyc   (cyc[g]),
      .wb_stb   (stb[g]),
      .wb_we    (we[g]),
      .wb_sel   (sel[g]),
      .wb_adr   (adr[g]),
      .wb_dat_i (dat_i[g]),
      .wb_stall (stall[g]),
      .wb_ack   (ack[g]),
      .wb_err   (err[g]),
      .wb_dat_o (dat_o[g]),
      .ram_addr (ram_addr[g]),
      .ram_ce   (ram_ce[g]),
      .ram_we   (ram_we[g]),
      .ram_d    (ram_d[g]),
      .ram_q    (q)
    );

    // Single-port RAM with byte enables and registered read data.
    always @(posedge clk) begin
      if (ram_ce[g]) begin
        for (int b = 0; b < 4; b++)
          if (ram_we[g][b]) mem[ram_addr[g]][8*b +: 8] <= ram_d[g][8*b +: 8];
        q <= mem[ram_addr[g]];
      end
    end
  end

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic logic [31:0] base_of(input int i);
    return (i == 0) ? BASE0 : BASE1;
  endfunction

  // Drive one bus cycle just after the rising edge, return at the falling edge for sampling.
  task automatic step(input int i, input bit c, input bit s, input bit w,
                      input logic [3:0] sl, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    cyc[i] = c; stb[i] = s; we[i] = w; sel[i] = sl; adr[i] = a; dat_i[i] = d;
    @(negedge clk);
  endtask

  task automatic ref_write(input int i, input int wi, input logic [3:0] sl, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (sl[b]) ref_mem[i][wi][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (ack[i] !== 1'b0 || err[i] !== 1'b0) begin
        fails++; $display("[TB] FAIL reset_ack_err[%0d]: got ack=%b err=%b want 0 0", i, ack[i], err[i]);
      end
      tests++;
      if (dat_o[i] !== 32'h0) begin
        fails++; $display("[TB] FAIL reset_dat[%0d]: got %h want 0", i, dat_o[i]);
      end
    end
    tests++;
    if (stall !== 2'b01) begin
      fails++; $display("[TB] FAIL reset_stall: got %b want 01", stall);
    end
    tests++;
    if (ram_ce[1] !== 1'b0 || ram_we[1] !== 4'h0) begin
      fails++; $display("[TB] FAIL reset_ram_ce: got ce=%b we=%h want 0 0", ram_ce[1], ram_we[1]);
    end
  endtask

  task automatic test_clear();
    int n;
    int bad;
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    tests++;
    if (stall[0] !== 1'b1) begin
      fails++; $display("[TB] FAIL mid_clear_stall: got %b want 1", stall[0]);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    n = 0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (stall[0] !== 1'b1) break;
      if (ram_ce[0] !== 1'b1 || ram_we[0] !== 4'hF || ram_d[0] !== 32'h0 || ram_addr[0] !== 5'(n)) bad++;
      if (stall[1] !== 1'b0) bad++;
      n++;
    end
    tests++;
    if (n != WORDS) begin
      fails++; $display("[TB] FAIL clear_len: got %0d stalled cycles want %0d", n, WORDS);
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("[TB] FAIL clear_drive: got %0d bad cycles want 0", bad);
    end
    for (int w = 0; w < WORDS; w++) ref_mem[0][w] = 32'h0;
    step(0, 1, 1, 0, 4'hF, 32'h7C, 32'h0);
    tests++;
    if (ram_ce[0] !== 1'b1 || ram_addr[0] !== 5'd31) begin
      fails++; $display("[TB] FAIL clear_read_ce: got ce=%b addr=%0d want 1 31", ram_ce[0], ram_addr[0]);
    end
    step(0, 1, 0, 0, 4'h0, 32'h0, 32'h0);
    tests++;
    if (ack[0] !== 1'b1 || dat_o[0] !== 32'h0) begin
      fails++; $display("[TB] FAIL clear_read_data: got ack=%b dat=%h want 1 0", ack[0], dat_o[0]);
    end
    step(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_preload(input int i);
    int acks;
    int errs;
    logic [31:0] d;
    acks = 0;
    errs = 0;
    for (int k = 0; k < WORDS + 4; k++) begin
      d = $urandom;
      if (k < WORDS) begin
        step(i, 1, 1, 1, 4'hF, base_of(i) + 32'(4 * k), d);
        ref_write(i, k, 4'hF, d);
      end else begin
        step(i, 1, 0, 0, 4'h0, 32'h0, 32'h0);
      end
      if (ack[i] === 1'b1) acks++;
      if (err[i] === 1'b1) errs++;
    end
    tests++;
    if (acks != WORDS || errs != 0) begin
      fails++; $display("[TB] FAIL preload[%0d]: got acks=%0d errs=%0d want %0d 0", i, acks, errs, WORDS);
    end
    step(i, 0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_write_read(input int i);
    logic        a_obs [6];
    logic [31:0] d_obs [6];
    int L;
    L = lat(i);
    for (int k = 0; k < 6; k++) begin
      if (k == 0)      step(i, 1, 1, 1, 4'hF, base_of(i) + 32'h10, 32'hDEADBEEF);
      else if (k == 1) step(i, 1, 1, 0, 4'hF, base_of(i) + 32'h10, 32'h0);
      else             step(i, 1, 0, 0, 4'h0, 32'h0, 32'h0);
      a_obs[k] = ack[i];
      d_obs[k] = dat_o[i];
    end
    ref_write(i, 4, 4'hF, 32'hDEADBEEF);
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (a_obs[k] !== ((k == L) || (k == L + 1))) begin
        fails++; $display("[TB] FAIL wr_rd_ack[%0d] cycle %0d: got %b want %b", i, k, a_obs[k], (k == L) || (k == L + 1));
      end
    end
    tests++;
    if (d_obs[L+1] !== 32'hDEADBEEF) begin
      fails++; $display("[TB] FAIL wr_rd_data[%0d]: got %h want deadbeef", i, d_obs[L+1]);
    end
    step(i, 0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_byte_sel(input int i);
    logic        a_obs [8];
    logic [31:0] d_obs [8];
    int L;
    L = lat(i);
    for (int k = 0; k < 8; k++) begin
      case (k)
        0:       step(i, 1, 1, 1, 4'hF, base_of(i) + 32'h20, 32'h11223344);
        1:       step(i, 1, 1, 1, 4'h1, base_of(i) + 32'h20, 32'h000000AA);
        2:       step(i, 1, 1, 1, 4'h0, base_of(i) + 32'h20, 32'hFFFFFFFF);
        3:       step(i, 1, 1, 0, 4'hF, base_of(i) + 32'h20, 32'h0);
        default: step(i, 1, 0, 0, 4'h0, 32'h0, 32'h0);
      endcase
      a_obs[k] = ack[i];
      d_obs[k] = dat_o[i];
    end
    ref_mem[i][8] = 32'h112233AA;
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (a_obs[k] !== ((k >= L) && (k <= L + 3))) begin
        fails++; $display("[TB] FAIL bytesel_ack[%0d] cycle %0d: got %b want %b", i, k, a_obs[k], (k >= L) && (k <= L + 3));
      end
    end
    tests++;
    if (d_obs[L+3] !== 32'h112233AA) begin
      fails++; $display("[TB] FAIL bytesel_data[%0d]: got %h want 112233aa", i, d_obs[L+3]);
    end
    step(i, 0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back(input int i);
    int          widx [8];
    logic        a_obs [12];
    logic [31:0] d_obs [12];
    int          stalls;
    int          L;
    L = lat(i);
    stalls = 0;
    for (int k = 0; k < 8; k++) widx[k] = $urandom_range(0, WORDS - 1);
    for (int k = 0; k < 12; k++) begin
      if (k < 8) step(i, 1, 1, 0, 4'hF, base_of(i) + 32'(4 * widx[k]), 32'h0);
      else       step(i, 1, 0, 0, 4'h0, 32'h0, 32'h0);
      a_obs[k] = ack[i];
      d_obs[k] = dat_o[i];
      if (stall[i] !== 1'b0) stalls++;
    end
    for (int k = 0; k < 12; k++) begin
      tests++;
      if (a_obs[k] !== ((k >= L) && (k < L + 8))) begin
        fails++; $display("[TB] FAIL b2b_ack[%0d] cycle %0d: got %b want %b", i, k, a_obs[k], (k >= L) && (k < L + 8));
      end else if ((k >= L) && (k < L + 8)) begin
        tests++;
        if (d_obs[k] !== ref_mem[i][widx[k-L]]) begin
          fails++; $display("[TB] FAIL b2b_data[%0d] beat %0d: got %h want %h", i, k - L, d_obs[k], ref_mem[i][widx[k-L]]);
        end
      end
    end
    tests++;
    if (stalls != 0) begin
      fails++; $display("[TB] FAIL b2b_stall[%0d]: got %0d stalled cycles want 0", i, stalls);
    end
    step(i, 0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_out_of_range(input int i);
    int L;
    int ce_seen;
    logic [31:0] a;
    L = lat(i);
    for (int t = 0; t < 2; t++) begin
      a = (t == 0) ? base_of(i) + 32'(SIZE) : base_of(i) - 32'h4;
      ce_seen = 0;
      for (int k = 0; k < 4; k++) begin
        if (k == 0) step(i, 1, 1, 0, 4'hF, a, 32'h0);
        else        step(i, 1, 0, 0, 4'h0, 32'h0, 32'h0);
        if (ram_ce[i] !== 1'b0) ce_seen++;
        tests++;
        if (err[i] !== (k == L) || ack[i] !== 1'b0) begin
          fails++; $display("[TB] FAIL oor[%0d] adr %h cycle %0d: got ack=%b err=%b want 0 %b", i, a, k, ack[i], err[i], k == L);
        end
      end
      tests++;
      if (ce_seen != 0) begin
        fails++; $display("[TB] FAIL oor_ce[%0d] adr %h: got %0d ce cycles want 0", i, a, ce_seen);
      end
      step(i, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    end
  endtask

  task automatic test_cyc_drop(input int i);
    int L;
    int late;
    L = lat(i);
    late = 0;
    for (int k = 0; k < 10; k++) begin
      if (k < 3) step(i, 1, 1, 0, 4'hF, base_of(i) + 32'(4 * k), 32'h0);
      else       step(i, 0, 0, 0, 4'h0, 32'h0, 32'h0);
      if (k < 3 && k >= L) begin
        tests++;
        if (ack[i] !== 1'b1 || dat_o[i] !== ref_mem[i][k-L]) begin
          fails++; $display("[TB] FAIL drop_early_ack[%0d] cycle %0d: got ack=%b dat=%h want 1 %h", i, k, ack[i], dat_o[i], ref_mem[i][k-L]);
        end
      end
      if (k >= 4 && (ack[i] !== 1'b0 || err[i] !== 1'b0)) late++;
    end
    tests++;
    if (late != 0) begin
      fails++; $display("[TB] FAIL drop_late[%0d]: got %0d responses after cyc drop want 0", i, late);
    end
    for (int k = 0; k < L + 2; k++) begin
      if (k == 0) step(i, 1, 1, 0, 4'hF, base_of(i) + 32'hC, 32'h0);
      else        step(i, 1, 0, 0, 4'h0, 32'h0, 32'h0);
      tests++;
      if (ack[i] !== (k == L) || err[i] !== 1'b0) begin
        fails++; $display("[TB] FAIL drop_resume[%0d] cycle %0d: got ack=%b err=%b want %b 0", i, k, ack[i], err[i], k == L);
      end else if (k == L) begin
        tests++;
        if (dat_o[i] !== ref_mem[i][3]) begin
          fails++; $display("[TB] FAIL drop_resume_data[%0d]: got %h want %h", i, dat_o[i], ref_mem[i][3]);
        end
      end
    end
    step(i, 0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  typedef struct {
    int          due;
    bit          is_err;
    bit          is_rd;
    logic [31:0] data;
  } exp_t;

  task automatic test_random(input int i, input int n);
    exp_t        q[$];
    exp_t        e;
    int          L;
    int          r;
    bit          s, w, inr;
    logic [3:0]  sl;
    logic [31:0] a, d, b;
    L = lat(i);
    b = base_of(i);
    for (int t = 0; t < n + L + 2; t++) begin
      s  = (t < n) && ($urandom_range(0, 9) < 7);
      w  = 1'($urandom_range(0, 1));
      sl = 4'($urandom);
      d  = $urandom;
      r  = $urandom_range(0, 9);
      if (r == 0)                 a = b + 32'(SIZE) + 32'(4 * $urandom_range(0, 63));
      else if (r == 1 && b >= 4)  a = b - 32'(4 * $urandom_range(1, 4));
      else                        a = b + 32'(4 * $urandom_range(0, WORDS - 1));
      step(i, 1, s, w, sl, a, d);
      inr = (a >= b) && ((a - b) < SIZE);
      tests++;
      if (ram_ce[i] !== (s && inr) || stall[i] !== 1'b0) begin
        fails++; $display("[TB] FAIL rnd_ce[%0d] t=%0d adr %h: got ce=%b stall=%b want %b 0", i, t, a, ram_ce[i], stall[i], s && inr);
      end
      if (s) begin
        e.due = t + L; e.is_err = !inr; e.is_rd = !w; e.data = 32'h0;
        if (inr) begin
          if (w) ref_write(i, (a - b) / 4, sl, d);
          else   e.data = ref_mem[i][(a - b) / 4];
        end
        q.push_back(e);
      end
      tests++;
      if (q.size() > 0 && q[0].due == t) begin
        e = q.pop_front();
        if (ack[i] !== !e.is_err || err[i] !== e.is_err) begin
          fails++; $display("[TB] FAIL rnd_resp[%0d] t=%0d: got ack=%b err=%b want %b %b", i, t, ack[i], err[i], !e.is_err, e.is_err);
        end else if (e.is_rd && !e.is_err && dat_o[i] !== e.data) begin
          fails++; $display("[TB] FAIL rnd_data[%0d] t=%0d: got %h want %h", i, t, dat_o[i], e.data);
        end
      end else if (ack[i] !== 1'b0 || err[i] !== 1'b0) begin
        fails++; $display("[TB] FAIL rnd_idle[%0d] t=%0d: got ack=%b err=%b want 0 0", i, t, ack[i], err[i]);
      end
    end
    tests++;
    if (q.size() != 0) begin
      fails++; $display("[TB] FAIL rnd_drain[%0d]: got %0d outstanding want 0", i, q.size());
    end
    step(i, 0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    cyc = '0; stb = '0; we = '0; sel = '0; adr = '0; dat_i = '0;
    test_reset();
    test_clear();
    test_preload(0);
    test_preload(1);
    for (int i = 0; i < 2; i++) begin
      test_write_read(i);
      test_byte_sel(i);
      test_back_to_back(i);
      test_out_of_range(i);
      test_cyc_drop(i);
      test_random(i, 200);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
